citadel_cmd_sched: RTL and testbench

// Bus-slave command scheduler in front of the citadel_gen accelerator. UDM CSR writes build a

---
 rtl/citadel_sched_pkg.sv | 46 ++++
 rtl/citadel_cmd_sched_sync_fifo.sv | 65 ++++++
 rtl/citadel_cmd_sched.sv | 228 ++++++++++++++++++++++
 tb/tb_citadel_cmd_sched.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/citadel_sched_pkg.sv
// Shared definitions for the citadel command scheduler: command payload layout,
// CSR offsets inside the 256-byte window, STATUS bit positions and issue FSM states.
// No ports; imported by citadel_cmd_sched and its queues.
package citadel_sched_pkg;

    // Command payload presented to citadel_gen (exec is the MSB of the packed word).
    typedef struct packed {
        logic        exec;
        logic        rf_we;
        logic [4:0]  rf_addr;
        logic [31:0] rf_wdata;
        logic [2:0]  fu_id;
        logic [3:0]  fu_opcode;
        logic [4:0]  fu_rs0;
        logic [4:0]  fu_rs1;
        logic [4:0]  fu_rd;
    } citadel_gen_cmd_req_struct;

    // CSR byte offsets within the window
    localparam logic [7:0] CTRL_OFS      = 8'h00;
    localparam logic [7:0] EXEC_OFS      = 8'h04;
    localparam logic [7:0] RF_WE_OFS     = 8'h08;
    localparam logic [7:0] RF_ADDR_OFS   = 8'h0C;
    localparam logic [7:0] RF_WDATA_OFS  = 8'h10;
    localparam logic [7:0] FU_ID_OFS     = 8'h14;
    localparam logic [7:0] FU_OPCODE_OFS = 8'h18;
    localparam logic [7:0] FU_RS0_OFS    = 8'h1C;
    localparam logic [7:0] FU_RS1_OFS    = 8'h20;
    localparam logic [7:0] FU_RD_OFS     = 8'h24;
    localparam logic [7:0] RDATA_OFS     = 8'h40;
    localparam logic [7:0] STATUS_OFS    = 8'h44;
    localparam logic [7:0] ERRCLR_OFS    = 8'h48;

    // STATUS register layout
    localparam int ST_CMDQ_LSB  = 0;
    localparam int ST_RESPQ_LSB = 8;
    localparam int ST_BUSY_BIT  = 16;
    localparam int ST_OVF_BIT   = 24;
    localparam int ST_UNF_BIT   = 25;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } sched_state_e;

endpackage

// File: rtl/citadel_cmd_sched_sync_fifo.sv
// Synchronous show-ahead FIFO, DEPTH = 2**DEPTH_POW entries of WIDTH bits.
// Latency: a write is visible at rdata_bo/count_bo on the next cycle; head is combinational.
// Backpressure: wr_i on full is ignored unless rd_i pops in the same cycle; clr_i wins over rd_i and
// is applied before a same-cycle wr_i.
// Ports: clk_i, rst_ni, wr_i/wdata_bi (push), rd_i/rdata_bo (pop, head), full_o, empty_o,
// count_bo (DEPTH_POW+1 bits), clr_i (synchronous flush).
module sync_fifo #(
    parameter int WIDTH     = 32,
    parameter int DEPTH_POW = 3
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 wr_i,
    input  logic [WIDTH-1:0]     wdata_bi,
    input  logic                 rd_i,
    output logic [WIDTH-1:0]     rdata_bo,
    output logic                 full_o,
    output logic                 empty_o,
    output logic [DEPTH_POW:0]   count_bo,
    input  logic                 clr_i
);

    localparam int DEPTH = 1 << DEPTH_POW;

    logic [WIDTH-1:0]     mem_q [DEPTH];
    logic [DEPTH_POW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [DEPTH_POW-1:0] wp_base, rp_base;
    logic [DEPTH_POW:0]   cnt_q, cnt_d, cnt_base;
    logic                 rd_go, wr_go;

    assign empty_o  = (cnt_q == '0);
    assign full_o   = cnt_q[DEPTH_POW];
    assign count_bo = cnt_q;
    assign rdata_bo = mem_q[rd_ptr_q];

    // A clear rewinds the pointers first, so a same-cycle write lands in slot 0.
    assign rd_go    = rd_i & ~clr_i & ~empty_o;
    assign wr_go    = wr_i & (clr_i | ~full_o | rd_go);
    assign wp_base  = clr_i ? '0 : wr_ptr_q;
    assign rp_base  = clr_i ? '0 : rd_ptr_q;
    assign cnt_base = clr_i ? '0 : cnt_q;

    assign wr_ptr_d = wp_base + DEPTH_POW'(wr_go);
    assign rd_ptr_d = rp_base + DEPTH_POW'(rd_go);
    assign cnt_d    = cnt_base + (DEPTH_POW+1)'(wr_go) - (DEPTH_POW+1)'(rd_go);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr_go) begin
            mem_q[wp_base] <= wdata_bi;
        end
    end

endmodule

// File: rtl/citadel_cmd_sched.sv
// CSR-driven command scheduler feeding citadel_gen through a command queue, with a response queue.
// Latency: CSR writes take effect next cycle; reads respond next cycle; PUSH -> cmd_req_o two cycles later.
// Backpressure: cmd_req_o/cmd_data_bo held until cmd_ack_i; PUSH to a full cmdq is dropped (OVF);
// resp_ack_o deasserts while the response queue is full.
// Ports: clk_i/rst_ni; bus_* UDM slave (ack combinational, resp/rdata one cycle after a read);
// cmd_req_o/cmd_data_bo/cmd_ack_i to citadel_gen; resp_req_i/resp_wdata_bi/resp_ack_o from citadel_gen.
module citadel_cmd_sched
    import citadel_sched_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h1000_0000,
    parameter int          CMDQ_POW  = 3,
    parameter int          RESPQ_POW = 3
) (
    input  logic                                         clk_i,
    input  logic                                         rst_ni,
    input  logic                                         bus_req_i,
    input  logic                                         bus_we_i,
    input  logic [31:0]                                  bus_addr_bi,
    input  logic [3:0]                                   bus_be_bi,
    input  logic [31:0]                                  bus_wdata_bi,
    output logic                                         bus_ack_o,
    output logic                                         bus_resp_o,
    output logic [31:0]                                  bus_rdata_bo,
    output logic                                         cmd_req_o,
    output logic [$bits(citadel_gen_cmd_req_struct)-1:0] cmd_data_bo,
    input  logic                                         cmd_ack_i,
    input  logic                                         resp_req_i,
    input  logic [31:0]                                  resp_wdata_bi,
    output logic                                         resp_ack_o
);

    localparam int CMD_W = $bits(citadel_gen_cmd_req_struct);
    localparam logic [CMDQ_POW:0] CMDQ_DEPTH = {1'b1, {CMDQ_POW{1'b0}}};

    // ---------------- bus decode ----------------
    logic [31:0] win_ofs;
    logic [7:0]  reg_ofs;
    logic        in_win, wr_acc, rd_acc;
    logic        push_req, flush, rdata_rd, errclr;

    assign win_ofs   = bus_addr_bi - BASE_ADDR;
    assign in_win    = (win_ofs[31:8] == 24'd0);
    assign reg_ofs   = win_ofs[7:0];
    assign bus_ack_o = bus_req_i & in_win;
    assign wr_acc    = bus_ack_o & bus_we_i;
    assign rd_acc    = bus_ack_o & ~bus_we_i;

    assign push_req  = wr_acc & (reg_ofs == CTRL_OFS) & bus_wdata_bi[0];
    assign flush     = wr_acc & (reg_ofs == CTRL_OFS) & bus_wdata_bi[1];
    assign errclr    = wr_acc & (reg_ofs == ERRCLR_OFS);
    assign rdata_rd  = rd_acc & (reg_ofs == RDATA_OFS);

    // ---------------- state ----------------
    citadel_gen_cmd_req_struct stg_q, cmd_data_q, cmd_data_d, cq_head_s;
    sched_state_e              state_q, state_d;
    logic                      inflight_q, inflight_d;
    logic                      ovf_q, unf_q;
    logic                      bus_resp_q;
    logic [31:0]               bus_rdata_q;

    // ---------------- command queue ----------------
    // The command being offered to citadel_gen lives in cmd_data_q, not in the FIFO, so the next
    // head is already at the FIFO output when the ack arrives (back-to-back issue). inflight_q keeps
    // that entry counted as cmdq occupancy until it is acked or flushed.
    logic [CMD_W-1:0]  cq_head;
    logic              cq_wr, cq_rd, cq_full, cq_empty;
    logic [CMDQ_POW:0] cq_cnt, cq_cnt_l;
    logic              cq_full_l, slot_free, push_ok;

    assign cq_head_s = citadel_gen_cmd_req_struct'(cq_head);
    assign cq_cnt_l  = cq_cnt + {{CMDQ_POW{1'b0}}, inflight_q};
    assign cq_full_l = (cq_cnt_l == CMDQ_DEPTH);
    assign slot_free = (state_q == ISSUE) & cmd_ack_i & inflight_q;
    assign push_ok   = push_req & (flush | ~cq_full_l | slot_free);
    assign cq_wr     = push_ok;

    sync_fifo #(
        .WIDTH     (CMD_W),
        .DEPTH_POW (CMDQ_POW)
    ) u_cmdq (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .wr_i     (cq_wr),
        .wdata_bi (stg_q),
        .rd_i     (cq_rd),
        .rdata_bo (cq_head),
        .full_o   (cq_full),
        .empty_o  (cq_empty),
        .count_bo (cq_cnt),
        .clr_i    (flush)
    );

    // ---------------- response queue ----------------
    logic [31:0]        rq_head;
    logic               rq_wr, rq_rd, rq_full, rq_empty;
    logic [RESPQ_POW:0] rq_cnt;

    assign resp_ack_o = ~rq_full;
    assign rq_wr      = resp_req_i & ~rq_full;
    assign rq_rd      = rdata_rd & ~rq_empty;

    sync_fifo #(
        .WIDTH     (32),
        .DEPTH_POW (RESPQ_POW)
    ) u_respq (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .wr_i     (rq_wr),
        .wdata_bi (resp_wdata_bi),
        .rd_i     (rq_rd),
        .rdata_bo (rq_head),
        .full_o   (rq_full),
        .empty_o  (rq_empty),
        .count_bo (rq_cnt),
        .clr_i    (flush)
    );

    // ---------------- issue FSM ----------------
    always_comb begin
        state_d    = state_q;
        cmd_data_d = cmd_data_q;
        inflight_d = inflight_q;
        cq_rd      = 1'b0;
        // A flush drops the in-flight entry from the count but never retracts cmd_req_o.
        if (flush) begin
            inflight_d = 1'b0;
        end
        case (state_q)
            IDLE: begin
                if (!cq_empty && !flush) begin
                    cq_rd      = 1'b1;
                    cmd_data_d = cq_head_s;
                    inflight_d = 1'b1;
                    state_d    = ISSUE;
                end
            end
            ISSUE: begin
                if (cmd_ack_i) begin
                    if (!cq_empty && !flush) begin
                        cq_rd      = 1'b1;
                        cmd_data_d = cq_head_s;
                        inflight_d = 1'b1;
                    end else begin
                        inflight_d = 1'b0;
                        state_d    = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign cmd_req_o   = (state_q == ISSUE);
    assign cmd_data_bo = cmd_data_q;

    // ---------------- read mux ----------------
    logic [31:0] status_w, rd_val;

    always_comb begin
        status_w = '0;
        status_w[ST_CMDQ_LSB  +: CMDQ_POW+1]  = cq_cnt_l;
        status_w[ST_RESPQ_LSB +: RESPQ_POW+1] = rq_cnt;
        status_w[ST_BUSY_BIT] = (state_q != IDLE);
        status_w[ST_OVF_BIT]  = ovf_q;
        status_w[ST_UNF_BIT]  = unf_q;
    end

    always_comb begin
        rd_val = '0;
        case (reg_ofs)
            RDATA_OFS:  rd_val = rq_empty ? 32'd0 : rq_head;
            STATUS_OFS: rd_val = status_w;
            default:    rd_val = '0;
        endcase
    end

    assign bus_resp_o   = bus_resp_q;
    assign bus_rdata_bo = bus_rdata_q;

    // ---------------- registers ----------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            cmd_data_q  <= '0;
            inflight_q  <= 1'b0;
            stg_q       <= '0;
            ovf_q       <= 1'b0;
            unf_q       <= 1'b0;
            bus_resp_q  <= 1'b0;
            bus_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            cmd_data_q  <= cmd_data_d;
            inflight_q  <= inflight_d;
            bus_resp_q  <= rd_acc;
            bus_rdata_q <= rd_acc ? rd_val : 32'd0;

            if (errclr) begin
                ovf_q <= 1'b0;
                unf_q <= 1'b0;
            end else begin
                if (push_req && !push_ok) ovf_q <= 1'b1;
                if (rdata_rd && rq_empty) unf_q <= 1'b1;
            end

            if (wr_acc) begin
                case (reg_ofs)
                    EXEC_OFS:      stg_q.exec      <= bus_wdata_bi[0];
                    RF_WE_OFS:     stg_q.rf_we     <= bus_wdata_bi[0];
                    RF_ADDR_OFS:   stg_q.rf_addr   <= bus_wdata_bi[4:0];
                    RF_WDATA_OFS:  stg_q.rf_wdata  <= bus_wdata_bi;
                    FU_ID_OFS:     stg_q.fu_id     <= bus_wdata_bi[2:0];
                    FU_OPCODE_OFS: stg_q.fu_opcode <= bus_wdata_bi[3:0];
                    FU_RS0_OFS:    stg_q.fu_rs0    <= bus_wdata_bi[4:0];
                    FU_RS1_OFS:    stg_q.fu_rs1    <= bus_wdata_bi[4:0];
                    FU_RD_OFS:     stg_q.fu_rd     <= bus_wdata_bi[4:0];
                    default: ;
                endcase
            end
        end
    end

    // Byte enables carry no information for 32-bit-only access; the physical cmdq full flag is
    // superseded by the occupancy count that includes the in-flight command.
    logic unused_sig;
    assign unused_sig = ^{bus_be_bi, cq_full};

endmodule

// File: tb/tb_citadel_cmd_sched.sv
module tb_citadel_cmd_sched;

    localparam logic [31:0] BASE = 32'h1000_0000;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        bus_req_i, bus_we_i;
    logic [31:0] bus_addr_bi, bus_wdata_bi;
    logic [3:0]  bus_be_bi;
    logic        bus_ack_o, bus_resp_o;
    logic [31:0] bus_rdata_bo;
    logic        cmd_req_o, cmd_ack_i;
    logic [60:0] cmd_data_bo;
    logic        resp_req_i, resp_ack_o;
    logic [31:0] resp_wdata_bi;

    int n_vec = 0;
    int n_err = 0;

    // Bench copy of the staging register fields.
    logic        e_exec, e_rfwe;
    logic [4:0]  e_rfaddr, e_rs0, e_rs1, e_rd;
    logic [31:0] e_rfwdata;
    logic [2:0]  e_fuid;
    logic [3:0]  e_fuop;
    logic [60:0] exp_q [8];

    always #5 clk_i = ~clk_i;

    citadel_cmd_sched dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .bus_req_i     (bus_req_i),
        .bus_we_i      (bus_we_i),
        .bus_addr_bi   (bus_addr_bi),
        .bus_be_bi     (bus_be_bi),
        .bus_wdata_bi  (bus_wdata_bi),
        .bus_ack_o     (bus_ack_o),
        .bus_resp_o    (bus_resp_o),
        .bus_rdata_bo  (bus_rdata_bo),
        .cmd_req_o     (cmd_req_o),
        .cmd_data_bo   (cmd_data_bo),
        .cmd_ack_i     (cmd_ack_i),
        .resp_req_i    (resp_req_i),
        .resp_wdata_bi (resp_wdata_bi),
        .resp_ack_o    (resp_ack_o)
    );

    function logic [60:0] exp_cmd();
        return {e_exec, e_rfwe, e_rfaddr, e_rfwdata, e_fuid, e_fuop, e_rs0, e_rs1, e_rd};
    endfunction

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic bus_wr(input logic [7:0] ofs, input logic [31:0] d);
        bus_req_i    = 1'b1;
        bus_we_i     = 1'b1;
        bus_addr_bi  = BASE + {24'd0, ofs};
        bus_wdata_bi = d;
        tick();
        bus_req_i    = 1'b0;
        bus_we_i     = 1'b0;
    endtask

    task automatic bus_rd(input logic [31:0] addr, output logic ack, output logic resp,
                          output logic [31:0] d);
        bus_req_i   = 1'b1;
        bus_we_i    = 1'b0;
        bus_addr_bi = addr;
        #1 ack = bus_ack_o;
        @(posedge clk_i);
        #1;
        bus_req_i = 1'b0;
        @(negedge clk_i);
        resp = bus_resp_o;
        d    = bus_rdata_bo;
        tick();
    endtask

    task automatic rd_chk(input string tag, input logic [7:0] ofs, input logic [31:0] exp);
        logic a, r;
        logic [31:0] d;
        bus_rd(BASE + {24'd0, ofs}, a, r, d);
        chk({tag, "_resp"}, r, 1'b1);
        chk(tag, d, exp);
    endtask

    task automatic push_cmd(input logic [31:0] wd);
        bus_wr(8'h10, wd);
        e_rfwdata = wd;
        bus_wr(8'h00, 32'h1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        logic a, r;
        logic [31:0] d;

        rst_ni = 1'b0;
        bus_req_i = 0; bus_we_i = 0; bus_addr_bi = 0; bus_wdata_bi = 0; bus_be_bi = 4'hF;
        cmd_ack_i = 0; resp_req_i = 0; resp_wdata_bi = 0;

        // ---- reset state ----
        tick(); tick();
        @(negedge clk_i);
        chk("rst_cmd_req", cmd_req_o, 1'b0);
        chk("rst_cmd_data", cmd_data_bo, 61'd0);
        chk("rst_bus_resp", bus_resp_o, 1'b0);
        chk("rst_rdata", bus_rdata_bo, 32'd0);
        tick();
        rst_ni = 1'b1;
        tick();
        rd_chk("rst_status", 8'h44, 32'h0);

        // ---- single command, ack tied high ----
        cmd_ack_i = 1'b1;
        bus_wr(8'h04, 32'h0000_0001); e_exec    = 1'b1;
        bus_wr(8'h08, 32'h0000_0003); e_rfwe    = 1'b1;
        bus_wr(8'h0C, 32'hFFFF_FFF5); e_rfaddr  = 5'h15;
        bus_wr(8'h10, 32'hDEAD_BEEF); e_rfwdata = 32'hDEAD_BEEF;
        bus_wr(8'h14, 32'h0000_000E); e_fuid    = 3'h6;
        bus_wr(8'h18, 32'h0000_003A); e_fuop    = 4'hA;
        bus_wr(8'h1C, 32'h0000_0023); e_rs0     = 5'h03;
        bus_wr(8'h20, 32'h0000_001C); e_rs1     = 5'h1C;
        bus_wr(8'h24, 32'h0000_0031); e_rd      = 5'h11;
        bus_wr(8'h00, 32'h1);                  // cycle N
        @(negedge clk_i);
        chk("single_req_n1", cmd_req_o, 1'b0);
        tick(); @(negedge clk_i);
        chk("single_req_n2", cmd_req_o, 1'b1);
        chk("single_data", cmd_data_bo, exp_cmd());
        tick(); @(negedge clk_i);
        chk("single_req_n3", cmd_req_o, 1'b0);

        // ---- back-pressure: ack low for 5 cycles ----
        tick();
        cmd_ack_i = 1'b0;
        push_cmd(32'h1111_1111);
        tick();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_i);
            chk("bp_req_hold", cmd_req_o, 1'b1);
            chk("bp_data_hold", cmd_data_bo, exp_cmd());
            tick();
        end
        cmd_ack_i = 1'b1;
        @(negedge clk_i);
        chk("bp_req_ack", cmd_req_o, 1'b1);
        tick(); @(negedge clk_i);
        chk("bp_req_drop", cmd_req_o, 1'b0);
        tick();

        // ---- three queued commands issue back-to-back ----
        cmd_ack_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            push_cmd(32'h0000_00A1 + i);
            exp_q[i] = exp_cmd();
        end
        rd_chk("b2b_status", 8'h44, 32'h0001_0003);
        cmd_ack_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            chk("b2b_req", cmd_req_o, 1'b1);
            chk("b2b_data", cmd_data_bo, exp_q[i]);
            tick();
        end
        @(negedge clk_i);
        chk("b2b_req_end", cmd_req_o, 1'b0);
        tick();

        // ---- overflow: 9 pushes with ack low ----
        cmd_ack_i = 1'b0;
        for (int i = 0; i < 8; i++) begin
            push_cmd(32'h0000_00B0 + i);
            exp_q[i] = exp_cmd();
        end
        rd_chk("ovf_status8", 8'h44, 32'h0001_0008);
        push_cmd(32'h0000_00B8);
        rd_chk("ovf_status9", 8'h44, 32'h0101_0008);
        cmd_ack_i = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk_i);
            chk("ovf_drain_req", cmd_req_o, 1'b1);
            chk("ovf_drain_data", cmd_data_bo, exp_q[i]);
            tick();
        end
        @(negedge clk_i);
        chk("ovf_ninth_absent", cmd_req_o, 1'b0);
        tick(); tick();
        @(negedge clk_i);
        chk("ovf_ninth_absent2", cmd_req_o, 1'b0);
        tick();
        rd_chk("ovf_status_drained", 8'h44, 32'h0100_0000);
        bus_wr(8'h48, 32'h0);
        rd_chk("ovf_errclr", 8'h44, 32'h0);
        cmd_ack_i = 1'b0;

        // ---- response queue fill and drain ----
        for (int i = 0; i < 8; i++) begin
            resp_req_i    = 1'b1;
            resp_wdata_bi = 32'hC0DE_0000 + i;
            @(negedge clk_i);
            chk("rq_ack_open", resp_ack_o, 1'b1);
            tick();
        end
        resp_req_i = 1'b0;
        @(negedge clk_i);
        chk("rq_ack_full", resp_ack_o, 1'b0);
        tick();
        rd_chk("rq_status_full", 8'h44, 32'h0000_0800);
        for (int i = 0; i < 8; i++) begin
            rd_chk("rq_pop", 8'h40, 32'hC0DE_0000 + i);
        end
        @(negedge clk_i);
        chk("rq_ack_reopen", resp_ack_o, 1'b1);
        tick();
        rd_chk("rq_pop_empty", 8'h40, 32'h0);
        rd_chk("rq_status_unf", 8'h44, 32'h0200_0000);
        bus_wr(8'h48, 32'h0);

        // ---- flush during issue ----
        resp_req_i = 1'b1; resp_wdata_bi = 32'h0000_0055;
        tick();
        resp_req_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            push_cmd(32'h0000_00D0 + i);
            exp_q[i] = exp_cmd();
        end
        rd_chk("fl_status_pre", 8'h44, 32'h0001_0104);
        bus_wr(8'h00, 32'h2);
        rd_chk("fl_status_post", 8'h44, 32'h0001_0000);
        @(negedge clk_i);
        chk("fl_inflight_req", cmd_req_o, 1'b1);
        chk("fl_inflight_data", cmd_data_bo, exp_q[0]);
        tick();
        cmd_ack_i = 1'b1;
        @(negedge clk_i);
        chk("fl_ack_req", cmd_req_o, 1'b1);
        tick();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_i);
            chk("fl_no_reissue", cmd_req_o, 1'b0);
            tick();
        end
        cmd_ack_i = 1'b0;
        rd_chk("fl_status_end", 8'h44, 32'h0);

        // ---- decode ----
        bus_rd(BASE + 32'h80, a, r, d);
        chk("dec_unmapped_ack", a, 1'b1);
        chk("dec_unmapped_resp", r, 1'b1);
        chk("dec_unmapped_data", d, 32'h0);
        bus_rd(BASE + 32'h100, a, r, d);
        chk("dec_outside_ack", a, 1'b0);
        chk("dec_outside_resp", r, 1'b0);

        // ---- reset during issue ----
        push_cmd(32'h7777_0000);
        tick();
        @(negedge clk_i);
        chk("rst_mid_req_before", cmd_req_o, 1'b1);
        tick();
        rst_ni = 1'b0;
        #1;
        chk("rst_mid_req_drop", cmd_req_o, 1'b0);
        tick();
        rst_ni = 1'b1;
        tick();
        rd_chk("rst_mid_status", 8'h44, 32'h0);
        @(negedge clk_i);
        chk("rst_mid_req_after", cmd_req_o, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
